// File: rtl/mem_router_pkg.sv
// Shared types and helpers for the mem_router CPU-side memory router.
//   txn_state_t : peripheral transaction FSM states
//   acc_type_t  : classification of the current CPU access
//   window_hit  : address-window match helper (half-open window of 2^size bytes)
package mem_router_pkg;

   localparam int ADDR_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } txn_state_t;

   typedef enum logic [1:0] {
      ACC_NONE     = 2'd0,
      ACC_PERIPH   = 2'd1,
      ACC_CACHE    = 2'd2,
      ACC_UNMAPPED = 2'd3
   } acc_type_t;

   // Aligned window: compare only the bits above the window size.
   function automatic logic window_hit(input logic [ADDR_MAX_W-1:0] addr,
                                       input logic [ADDR_MAX_W-1:0] base,
                                       input logic [4:0]            size_log2);
      return (addr >> size_log2) == (base >> size_log2);
   endfunction

endpackage

// File: rtl/periph_txn_fsm.sv
// Peripheral transaction engine for mem_router: latches the request, issues a
// one-cycle AXI start pulse, waits for the matching completion and presents the
// result for one DONE cycle.
// Optional macro MEMCTRL_TIMEOUT_EN: abandons WAIT after TIMEOUT_CYCLES cycles
// and reports an error in the DONE cycle.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req, req_rw/addr/wdata/sel  decoded peripheral request (sampled in IDLE)
//   rd_data, rd_cpl, wr_cpl  AXI-master read data and completions
//   axi_addr, axi_wdata, sel latched request towards the AXI master
//   start_rd, start_wr       one-cycle start pulses
//   idle, done               FSM phase indications for the top-level mux
//   done_data, done_err      result presented in the DONE cycle
//
// state    | meaning
// ST_IDLE  | no transaction; latch a peripheral request when offered
// ST_START | pulse the AXI start matching the latched direction
// ST_WAIT  | hold the CPU until the matching completion (or timeout)
// ST_DONE  | release the CPU with the result for one cycle
module periph_txn_fsm
   import mem_router_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_PERIPH     = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  req_rw,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [NUM_PERIPH-1:0] req_sel,
   input  logic [DATA_W-1:0]     rd_data,
   input  logic                  rd_cpl,
   input  logic                  wr_cpl,
   output logic [ADDR_W-1:0]     axi_addr,
   output logic [DATA_W-1:0]     axi_wdata,
   output logic [NUM_PERIPH-1:0] sel,
   output logic                  start_rd,
   output logic                  start_wr,
   output logic                  idle,
   output logic                  done,
   output logic [DATA_W-1:0]     done_data,
   output logic                  done_err
);

   txn_state_t            state_q, state_d;
   logic                  rw_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [NUM_PERIPH-1:0] sel_q;
   logic [DATA_W-1:0]     data_q;
   logic                  err_q;
   logic                  accept;
   logic                  timeout_hit;

   // Only the completion that matches the latched direction counts.
   assign accept = (state_q == ST_WAIT) && (rw_q ? wr_cpl : rd_cpl);

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;

   // Limit reached on the TIMEOUT_CYCLES-th WAIT cycle; a completion wins.
   assign timeout_hit = (state_q == ST_WAIT) && !accept &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == ST_START) begin
         cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (req) state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (accept || timeout_hit) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // data_q is cleared at latch so writes and timeouts return 0.
         if (state_q == ST_IDLE && req) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            sel_q   <= req_sel;
            data_q  <= '0;
            err_q   <= 1'b0;
         end
         if (accept && !rw_q) data_q <= rd_data;
         if (timeout_hit)     err_q  <= 1'b1;
      end
   end

   assign axi_addr  = addr_q;
   assign axi_wdata = wdata_q;
   assign sel       = (state_q == ST_IDLE) ? '0 : sel_q;
   assign start_rd  = (state_q == ST_START) && !rw_q;
   assign start_wr  = (state_q == ST_START) &&  rw_q;
   assign idle      = (state_q == ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign done_data = data_q;
   assign done_err  = err_q;

endmodule

// File: rtl/mem_router.sv
// mem_router: decodes CPU data accesses against NUM_PERIPH peripheral windows
// and one cache window. Peripheral accesses go through periph_txn_fsm (AXI
// start/complete handshake); cache accesses are forwarded combinationally;
// unmapped accesses produce a one-cycle BusErr.
// Optional macro MEMCTRL_TIMEOUT_EN: peripheral wait timeout (TIMEOUT_CYCLES).
// Ports:
//   Clk, Rst                 clock, async active-low reset
//   RW, En, Address, IData   CPU request; Stall, OData, BusErr CPU response
//   P_*                      AXI-master side (latched request, start pulses, completions)
//   C_*                      cache side (pass-through request, read data, stall)
module mem_router
   import mem_router_pkg::*;
#(
   parameter int                        ADDR_W           = 32,
   parameter int                        DATA_W           = 32,
   parameter int                        NUM_PERIPH       = 2,
   parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_BASE   = {32'h44A10000, 32'h44A00000},
   parameter logic [NUM_PERIPH*5-1:0]   PERIPH_SIZE_LOG2 = {5'd16, 5'd16},
   parameter logic [ADDR_W-1:0]         CACHE_BASE       = 32'h0,
   parameter int                        CACHE_SIZE_LOG2  = 16,
   parameter int                        TIMEOUT_CYCLES   = 256
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  RW,
   input  logic                  En,
   input  logic [ADDR_W-1:0]     Address,
   input  logic [DATA_W-1:0]     IData,
   output logic                  Stall,
   output logic [DATA_W-1:0]     OData,
   output logic                  BusErr,
   output logic [ADDR_W-1:0]     P_AXIAddr,
   output logic [DATA_W-1:0]     P_WriteData,
   output logic [NUM_PERIPH-1:0] P_Sel,
   output logic                  P_StartAXIRead,
   output logic                  P_StartAXIWrite,
   input  logic [DATA_W-1:0]     P_ReadData,
   input  logic                  P_ReadCompleted,
   input  logic                  P_WriteCompleted,
   output logic                  C_En,
   output logic                  C_RW,
   output logic [ADDR_W-1:0]     C_Address,
   output logic [DATA_W-1:0]     C_WriteData,
   input  logic [DATA_W-1:0]     C_ReadData,
   input  logic                  C_Stall
);

   logic                  periph_hit;
   logic                  cache_hit;
   logic [NUM_PERIPH-1:0] hit_sel;
   acc_type_t             acc;
   logic                  fsm_idle;
   logic                  fsm_done;
   logic [DATA_W-1:0]     fsm_data;
   logic                  fsm_err;

   // Scanning from the top index down lets the lowest matching window win.
   always_comb begin
      periph_hit = 1'b0;
      hit_sel    = '0;
      for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
         if (window_hit(ADDR_MAX_W'(Address),
                        ADDR_MAX_W'(PERIPH_BASE[i*ADDR_W +: ADDR_W]),
                        PERIPH_SIZE_LOG2[i*5 +: 5])) begin
            periph_hit = 1'b1;
            hit_sel    = '0;
            hit_sel[i] = 1'b1;
         end
      end
   end

   assign cache_hit = window_hit(ADDR_MAX_W'(Address), ADDR_MAX_W'(CACHE_BASE),
                                 5'(CACHE_SIZE_LOG2));

   always_comb begin
      acc = ACC_NONE;
      if (En) begin
         if (periph_hit)     acc = ACC_PERIPH;
         else if (cache_hit) acc = ACC_CACHE;
         else                acc = ACC_UNMAPPED;
      end
   end

   periph_txn_fsm #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .NUM_PERIPH     (NUM_PERIPH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_txn (
      .clk       (Clk),
      .rst_n     (Rst),
      .req       (acc == ACC_PERIPH),
      .req_rw    (RW),
      .req_addr  (Address),
      .req_wdata (IData),
      .req_sel   (hit_sel),
      .rd_data   (P_ReadData),
      .rd_cpl    (P_ReadCompleted),
      .wr_cpl    (P_WriteCompleted),
      .axi_addr  (P_AXIAddr),
      .axi_wdata (P_WriteData),
      .sel       (P_Sel),
      .start_rd  (P_StartAXIRead),
      .start_wr  (P_StartAXIWrite),
      .idle      (fsm_idle),
      .done      (fsm_done),
      .done_data (fsm_data),
      .done_err  (fsm_err)
   );

   // Cache is only touched while no peripheral transaction is in flight.
   always_comb begin
      Stall  = 1'b0;
      OData  = '0;
      BusErr = 1'b0;
      C_En   = 1'b0;
      if (fsm_idle) begin
         unique case (acc)
            ACC_PERIPH:   Stall = 1'b1;
            ACC_CACHE: begin
               C_En  = 1'b1;
               Stall = C_Stall;
               OData = C_ReadData;
            end
            ACC_UNMAPPED: BusErr = 1'b1;
            default:      ;
         endcase
      end else if (fsm_done) begin
         OData  = fsm_data;
         BusErr = fsm_err;
      end else begin
         Stall = 1'b1;
      end
   end

   assign C_RW        = RW;
   assign C_Address   = Address;
   assign C_WriteData = IData;

endmodule

// File: tb/tb_mem_router.sv
module tb_mem_router;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        RW, En;
   logic [31:0] Address, IData;
   logic        Stall, BusErr;
   logic [31:0] OData;
   logic [31:0] P_AXIAddr, P_WriteData, P_ReadData;
   logic [1:0]  P_Sel;
   logic        P_StartAXIRead, P_StartAXIWrite, P_ReadCompleted, P_WriteCompleted;
   logic        C_En, C_RW, C_Stall;
   logic [31:0] C_Address, C_WriteData, C_ReadData;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   mem_router #(.TIMEOUT_CYCLES(8)) dut (
      .Clk(Clk), .Rst(Rst), .RW(RW), .En(En), .Address(Address), .IData(IData),
      .Stall(Stall), .OData(OData), .BusErr(BusErr),
      .P_AXIAddr(P_AXIAddr), .P_WriteData(P_WriteData), .P_Sel(P_Sel),
      .P_StartAXIRead(P_StartAXIRead), .P_StartAXIWrite(P_StartAXIWrite),
      .P_ReadData(P_ReadData), .P_ReadCompleted(P_ReadCompleted),
      .P_WriteCompleted(P_WriteCompleted),
      .C_En(C_En), .C_RW(C_RW), .C_Address(C_Address), .C_WriteData(C_WriteData),
      .C_ReadData(C_ReadData), .C_Stall(C_Stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Cycle 0 is the IDLE decode cycle; completions are driven in cycles rc_from..rc_to / wc.
   task automatic periph_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int rc_from, input int rc_to,
                             input int wc, output int stalls, output int n_rd, output int n_wr,
                             output logic [31:0] od, output logic [1:0] sel, output logic berr,
                             output logic [31:0] ax_addr, output logic [31:0] ax_wdata);
      logic fin;
      fin = 1'b0; stalls = 0; n_rd = 0; n_wr = 0;
      od = 'x; sel = 'x; berr = 'x; ax_addr = 'x; ax_wdata = 'x;
      En = 1'b1; RW = rw; Address = addr; IData = wdata; P_ReadData = rdata;
      for (int c = 0; c < 40 && !fin; c++) begin
         P_ReadCompleted  = (c >= rc_from && c <= rc_to);
         P_WriteCompleted = (c == wc);
         @(negedge Clk);
         if (P_StartAXIRead)  n_rd++;
         if (P_StartAXIWrite) n_wr++;
         if (c == 1) begin
            sel = P_Sel; ax_addr = P_AXIAddr; ax_wdata = P_WriteData;
         end
         if (Stall) stalls++;
         else begin
            fin = 1'b1; od = OData; berr = BusErr;
         end
         step();
      end
      En = 1'b0; P_ReadCompleted = 1'b0; P_WriteCompleted = 1'b0;
      check("txn_finished", 32'(fin), 32'd1);
   endtask

   int          stalls, n_rd, n_wr;
   logic [31:0] od, ax_addr, ax_wdata;
   logic [1:0]  sel;
   logic        berr;

   initial begin
      Rst = 1'b0; RW = 1'b0; En = 1'b0; Address = '0; IData = '0;
      P_ReadData = '0; P_ReadCompleted = 1'b0; P_WriteCompleted = 1'b0;
      C_ReadData = '0; C_Stall = 1'b0;
      step(); step();
      @(negedge Clk);
      check("rst_stall", 32'(Stall), 0);
      check("rst_buserr", 32'(BusErr), 0);
      check("rst_odata", OData, 0);
      check("rst_psel", 32'(P_Sel), 0);
      check("rst_starts", 32'({P_StartAXIRead, P_StartAXIWrite}), 0);
      check("rst_cen", 32'(C_En), 0);
      step();
      Rst = 1'b1;
      step();

      // peripheral read, completion 4 cycles after the start pulse
      periph_txn(1'b0, 32'h44A00010, 32'h0, 32'hDEADBEEF, 5, 5, -1,
                 stalls, n_rd, n_wr, od, sel, berr, ax_addr, ax_wdata);
      check("rd_stalls", 32'(stalls), 6);
      check("rd_nstart_rd", 32'(n_rd), 1);
      check("rd_nstart_wr", 32'(n_wr), 0);
      check("rd_odata", od, 32'hDEADBEEF);
      check("rd_psel", 32'(sel), 32'h1);
      check("rd_axiaddr", ax_addr, 32'h44A00010);
      check("rd_buserr", 32'(berr), 0);
      step();

      // peripheral write; stray read completions must be ignored
      periph_txn(1'b1, 32'h44A10004, 32'h12345678, 32'hFFFFFFFF, 3, 4, 6,
                 stalls, n_rd, n_wr, od, sel, berr, ax_addr, ax_wdata);
      check("wr_stalls", 32'(stalls), 7);
      check("wr_nstart_wr", 32'(n_wr), 1);
      check("wr_nstart_rd", 32'(n_rd), 0);
      check("wr_wdata", ax_wdata, 32'h12345678);
      check("wr_psel", 32'(sel), 32'h2);
      check("wr_axiaddr", ax_addr, 32'h44A10004);
      check("wr_odata", od, 0);
      step();

      // top-of-window read, both completions at the earliest cycle
      periph_txn(1'b0, 32'h44A1FFFC, 32'h0, 32'h0BADF00D, 2, 2, 2,
                 stalls, n_rd, n_wr, od, sel, berr, ax_addr, ax_wdata);
      check("edge_stalls", 32'(stalls), 3);
      check("edge_odata", od, 32'h0BADF00D);
      check("edge_psel", 32'(sel), 32'h2);
      @(negedge Clk);
      check("edge_psel_idle", 32'(P_Sel), 0);
      step();

      // cache read with two stall cycles
      En = 1'b1; RW = 1'b0; Address = 32'h00000100; C_ReadData = 32'hA5A5A5A5;
      for (int c = 0; c < 3; c++) begin
         C_Stall = (c < 2);
         @(negedge Clk);
         check("c_en", 32'(C_En), 1);
         check("c_stall_follow", 32'(Stall), 32'(c < 2));
         check("c_nostart", 32'({P_StartAXIRead, P_StartAXIWrite}), 0);
         if (c == 2) check("c_odata", OData, 32'hA5A5A5A5);
         step();
      end
      C_Stall = 1'b0;
      // cache write pass-through
      RW = 1'b1; Address = 32'h00000200; IData = 32'h55AA55AA;
      @(negedge Clk);
      check("cw_crw", 32'(C_RW), 1);
      check("cw_caddr", C_Address, 32'h00000200);
      check("cw_cwdata", C_WriteData, 32'h55AA55AA);
      check("cw_stall", 32'(Stall), 0);
      step();

      // first address past the cache window
      RW = 1'b0; Address = 32'h00010000;
      @(negedge Clk);
      check("um_stall", 32'(Stall), 0);
      check("um_odata", OData, 0);
      check("um_buserr", 32'(BusErr), 1);
      check("um_cen", 32'(C_En), 0);
      step();
      En = 1'b0;
      @(negedge Clk);
      check("um_buserr_drop", 32'(BusErr), 0);
      step();
      // first address past peripheral window 1
      En = 1'b1; Address = 32'h44A20000;
      @(negedge Clk);
      check("um2_buserr", 32'(BusErr), 1);
      check("um2_stall", 32'(Stall), 0);
      step();
      En = 1'b0;
      step();

      // reset during WAIT, then a late completion
      En = 1'b1; RW = 1'b0; Address = 32'h44A00020; P_ReadData = 32'h11111111;
      step(); step();
      @(negedge Clk);
      check("rw_wait_stall", 32'(Stall), 1);
      #2;
      Rst = 1'b0; En = 1'b0;
      #1;
      check("rw_rst_stall", 32'(Stall), 0);
      check("rw_rst_psel", 32'(P_Sel), 0);
      check("rw_rst_start", 32'({P_StartAXIRead, P_StartAXIWrite}), 0);
      step();
      Rst = 1'b1;
      P_ReadCompleted = 1'b1;
      @(negedge Clk);
      check("rw_late_stall", 32'(Stall), 0);
      check("rw_late_odata", OData, 0);
      step();
      P_ReadCompleted = 1'b0;
      @(negedge Clk);
      check("rw_after_odata", OData, 0);
      check("rw_after_start", 32'({P_StartAXIRead, P_StartAXIWrite}), 0);
      step();

`ifdef MEMCTRL_TIMEOUT_EN
      // no completion: DONE after 8 WAIT cycles
      periph_txn(1'b0, 32'h44A00040, 32'h0, 32'h77777777, -1, -2, -1,
                 stalls, n_rd, n_wr, od, sel, berr, ax_addr, ax_wdata);
      check("to_stalls", 32'(stalls), 10);
      check("to_buserr", 32'(berr), 1);
      check("to_odata", od, 0);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised successor to the CPU-side memory controller.
- Decodes each CPU data access against NUM_PERIPH peripheral windows and one cache window.
- Peripheral accesses run through a registered transaction FSM driving the AXI-master start/complete handshake; cache accesses are forwarded.
- Unmapped accesses return a bus-error pulse instead of silently reading 0.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_PERIPH, 2, number of peripheral windows (1..8).
- PERIPH_BASE, {32'h44A10000, 32'h44A00000}, packed NUM_PERIPH*ADDR_W vector of window bases; index 0 in the LSBs.
- PERIPH_SIZE_LOG2, {5'd16, 5'd16}, packed NUM_PERIPH*5 vector of log2 window sizes.
- CACHE_BASE, 32'h0, cache window base.
- CACHE_SIZE_LOG2, 16, log2 cache window size.
- TIMEOUT_CYCLES, 256, peripheral wait limit; used only with the optional feature.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset; asynchronous, active-low.
- RW  in  1  1 = write, 0 = read.
- En  in  1  access request; held with Address/IData while Stall = 1.
- Address  in  ADDR_W  CPU address.
- IData  in  DATA_W  CPU write data.
- Stall  out  1  CPU must hold its request.
- OData  out  DATA_W  read data.
- BusErr  out  1  one-cycle error pulse.
- P_AXIAddr  out  ADDR_W  latched peripheral address.
- P_WriteData  out  DATA_W  latched write data.
- P_Sel  out  NUM_PERIPH  one-hot latched window select.
- P_StartAXIRead  out  1  one-cycle read start pulse.
- P_StartAXIWrite  out  1  one-cycle write start pulse.
- P_ReadData  in  DATA_W  AXI read data.
- P_ReadCompleted  in  1  read done.
- P_WriteCompleted  in  1  write done.
- C_En  out  1  cache enable.
- C_RW  out  1  cache direction.
- C_Address  out  ADDR_W  cache address.
- C_WriteData  out  DATA_W  cache write data.
- C_ReadData  in  DATA_W  cache read data.
- C_Stall  in  1  cache stall.

Behaviour:
- Decode (combinational): window i hits when (Address >> PERIPH_SIZE_LOG2[i]) == (PERIPH_BASE[i] >> PERIPH_SIZE_LOG2[i]). Window bounds are half-open; the top address base+2^size is not in the window.
- Priority: the lowest-index peripheral window wins, then the cache window. No hit with En = 1 is unmapped.
- Reset values: state IDLE; all registers 0; Stall, BusErr, start pulses, P_Sel, OData all 0.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - Peripheral hit: latch Address, IData, RW and one-hot select; go to START. Stall = 1 combinationally in this cycle.
  - Cache hit: C_En = 1, Stall = C_Stall, OData = C_ReadData.
  - Unmapped: Stall = 0, OData = 0, BusErr = 1 for that cycle.
  - En = 0: all outputs idle.
- START: pulse P_StartAXIRead or P_StartAXIWrite for exactly 1 cycle; Stall = 1; go to WAIT.
- WAIT: Stall = 1.
  - Only the completion matching the latched RW is accepted; the other completion is ignored, including when both are asserted together.
  - On a read completion, latch P_ReadData.
  - On either accepted completion, go to DONE.
  - Earliest completion is the cycle after START, giving minimum peripheral latency of 3 stalled cycles.
- DONE:
  - Stall = 0, OData = latched data (0 for writes). The CPU samples in this cycle.
  - Next state is IDLE unconditionally; a new request is decoded in the following cycle.
- C_En is 0 in every state except IDLE, so there are no cache accesses during a peripheral transaction.
- C_RW, C_Address and C_WriteData are always the CPU RW, Address and IData.
- P_AXIAddr, P_WriteData and P_Sel hold the latched values until the next latch. P_Sel returns to 0 in IDLE.
- Completions arriving in IDLE, START or DONE are ignored.
- Reset asserted mid-transaction forces IDLE immediately and drops all start pulses; late completions are then ignored.

Optional Feature:
- Macro: MEMCTRL_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no completion, go to DONE with OData = 0 and BusErr = 1 for the DONE cycle.
  - A completion in the same cycle as the limit wins, with no error.
- Not defined: WAIT persists indefinitely; BusErr flags unmapped accesses only.

Decomposition:
- Package mem_router_pkg:
  - state enum (IDLE/START/WAIT/DONE);
  - access-type encoding (NONE/PERIPH/CACHE/UNMAPPED);
  - function window_hit(addr, base, size_log2).
- One sub-module, periph_txn_fsm: the FSM, latches, start pulses and timeout counter.
- The top level holds the decode and the muxing.

Test Plan:
- Read at 32'h44A00010; P_ReadCompleted with P_ReadData = 32'hDEADBEEF 4 cycles after start -> exactly one start pulse; Stall high 6 cycles; OData = 32'hDEADBEEF in the DONE cycle; P_Sel = 2'b01.
- Write 32'h12345678 to 32'h44A10004 -> P_StartAXIWrite pulse; P_WriteData = 32'h12345678; P_Sel = 2'b10; P_ReadCompleted asserted alone is ignored; release occurs only on P_WriteCompleted.
- Read at 32'h00000100 with C_Stall high 2 cycles and C_ReadData = 32'hA5A5A5A5 -> C_En = 1; Stall follows C_Stall; OData = 32'hA5A5A5A5; no AXI starts.
- Read at 32'h00010000 (first address past the cache window) -> Stall = 0, OData = 0, BusErr one-cycle pulse, C_En = 0.
- Rst low during WAIT, then P_ReadCompleted after release -> IDLE, no Stall, no OData update, no start pulse.
- With MEMCTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no completion -> DONE after 8 WAIT cycles; BusErr = 1; OData = 0.
